iob_split_pipe: RTL

//  Parametrised, pipelined successor to the single-outstanding IOb address splitter.
//  - Routes one IOb-native master to N_SLAVES slaves, decoding a select field in the address.
//  - Uses a split request/response handshake and allows up to MAX_RD reads in flight.
//  - Unmapped select values go to an internal error responder.
//  - Sits between the CPU data bus and the peripheral / memory buses.

---
 rtl/iob_split_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/iob_split_pipe.sv
// Pipelined IOb address splitter: one master, N_SLAVES slaves, up to
// MAX_RD in-order reads in flight and an internal error responder.
module iob_split_pipe #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                N_SLAVES = 4,
    parameter int                P_SLAVES = ADDR_W - 2,
    parameter int                MAX_RD   = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_valid,
    input  logic [ADDR_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]          m_wdata,
    input  logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_ready,
    output logic                       m_rvalid,
    output logic [DATA_W-1:0]          m_rdata,
    output logic [N_SLAVES-1:0]        s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [DATA_W/8-1:0]        s_wstrb,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES-1:0]        s_rvalid,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    output logic                       err
);

    localparam int SEL_W = $clog2(N_SLAVES);
    localparam int IDX_W = SEL_W + 1;
    localparam int CNT_W = $clog2(MAX_RD + 1);
    localparam logic [IDX_W-1:0] UNMAP   = IDX_W'(N_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RD);

    logic [SEL_W-1:0]  sel;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  rd_sel;
    logic [CNT_W-1:0]  cnt;
    logic              is_read;
    logic              unmapped;
    logic              stall;
    logic              sel_rdy;
    logic              own_rvalid;
    logic [DATA_W-1:0] own_rdata;
    logic              accept;
    logic              rd_accept;
    logic              err_rd;

    assign sel      = m_addr[P_SLAVES -: SEL_W];
    assign sel_idx  = ({1'b0, sel} >= UNMAP) ? UNMAP : {1'b0, sel};
    assign unmapped = (sel_idx == UNMAP);
    assign is_read  = (m_wstrb == '0);

    // A read waits if the window is full or if it targets a different
    // slave than the reads still in flight, which keeps responses ordered.
    assign stall = is_read & ((cnt == CNT_MAX) |
                              ((cnt != '0) & (sel_idx != rd_sel)));

    // Request routing by sel and response selection by owning slave.
    always_comb begin
        sel_rdy    = 1'b0;
        own_rvalid = 1'b0;
        own_rdata  = '0;
        s_valid    = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_rdy    = s_ready[i];
                s_valid[i] = m_valid & ~stall;
            end
            if (rd_sel == IDX_W'(i)) begin
                own_rvalid = s_rvalid[i];
                own_rdata  = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign m_ready   = ~stall & (unmapped | sel_rdy);
    assign accept    = m_valid & m_ready;
    assign rd_accept = accept & is_read;

    assign err_rd   = (rd_sel == UNMAP);
    assign m_rvalid = (cnt != '0) & (err_rd | own_rvalid);
    assign m_rdata  = !m_rvalid ? '0 : (err_rd ? ERR_DATA : own_rdata);

    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    assign s_wstrb = m_wstrb;

    // Outstanding-read count, owner of those reads and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            rd_sel <= '0;
            err    <= 1'b0;
        end else begin
            err <= accept & unmapped;
            if (rd_accept) begin
                rd_sel <= sel_idx;
            end
            if (rd_accept && !m_rvalid) begin
                cnt <= cnt + 1'b1;
            end else if (!rd_accept && m_rvalid) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
